// File: rtl/patch_reducer_scheduler.sv
// Patch row reducer scheduler: hands patch configs to idle reducers, collects
// their sums and returns them one at a time, tagged with the patch id.

module patch_reducer_slot #(
    parameter int FP_SIZE = 32,
    parameter int ID_SIZE = 16
) (
    input  logic               dram_clk,
    input  logic               reset,
    input  logic               dispatch,
    input  logic [ID_SIZE-1:0] id_in,
    input  logic               sum_rdy,
    input  logic [FP_SIZE-1:0] sum_in,
    input  logic               load,
    input  logic               accept,
    output logic               idle,
    output logic               pending,
    output logic               busy_next,
    output logic               proto_hit,
    output logic [FP_SIZE-1:0] sum,
    output logic [ID_SIZE-1:0] id
);
    typedef enum logic [1:0] {IDLE, DISPATCHED, DONE} slot_state_t;

    slot_state_t state, state_nxt;
    logic        loaded;

    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        proto_hit = sum_rdy && (state != DISPATCHED);
        case (state)
            IDLE:       if (dispatch) state_nxt = DISPATCHED;
            DISPATCHED: if (sum_rdy)  state_nxt = DONE;
            DONE:       if (accept)   state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // loaded marks a DONE slot whose sum already sits in the output register
    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset) begin
            id     <= '0;
            sum    <= '0;
            loaded <= 1'b0;
        end else begin
            if (dispatch && state == IDLE)      id  <= id_in;
            if (sum_rdy && state == DISPATCHED) sum <= sum_in;
            if (accept)    loaded <= 1'b0;
            else if (load) loaded <= 1'b1;
        end
    end

    assign idle      = (state == IDLE);
    assign pending   = (state == DONE) && !loaded;
    assign busy_next = (state_nxt != IDLE);
endmodule

module patch_reducer_scheduler #(
    parameter int N_REDUCER  = 4,
    parameter int N_COL_SIZE = 11,
    parameter int N_ROW_SIZE = 11,
    parameter int FP_SIZE    = 32,
    parameter int PATCH_SIZE = 6,
    parameter int ID_SIZE    = 16,
    localparam int IDX_W     = (N_REDUCER > 1) ? $clog2(N_REDUCER) : 1,
    localparam int CNT_W     = $clog2(N_REDUCER) + 1
) (
    input  logic                          dram_clk,
    input  logic                          reset,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [N_COL_SIZE-1:0]         cfg_col,
    input  logic [N_ROW_SIZE-1:0]         cfg_row,
    input  logic [PATCH_SIZE*FP_SIZE-1:0] cfg_weights,
    input  logic [ID_SIZE-1:0]            cfg_id,
    input  logic [N_REDUCER-1:0]          red_available,
    output logic [N_REDUCER-1:0]          red_init,
    output logic [N_COL_SIZE-1:0]         red_col,
    output logic [N_ROW_SIZE-1:0]         red_row,
    output logic [PATCH_SIZE*FP_SIZE-1:0] red_weights,
    input  logic [N_REDUCER-1:0]          red_sum_rdy,
    input  logic [N_REDUCER*FP_SIZE-1:0]  red_sum,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FP_SIZE-1:0]            out_sum,
    output logic [ID_SIZE-1:0]            out_id,
    output logic [IDX_W-1:0]              out_reducer,
    output logic [CNT_W-1:0]              busy_count,
    output logic                          proto_err
);
    logic [N_REDUCER-1:0] idle, pending, busy_next, proto_hit;
    logic [N_REDUCER-1:0] eligible, dispatch, load_vec, accept_vec;
    logic [FP_SIZE-1:0]   slot_sum [N_REDUCER];
    logic [ID_SIZE-1:0]   slot_id  [N_REDUCER];
    logic [IDX_W-1:0]     rr_idx   [N_REDUCER];
    logic [IDX_W-1:0]     rr_ptr, pick;
    logic                 handshake, accept, pick_found, load_en;
    logic [CNT_W-1:0]     busy_sum;

    assign eligible  = idle & red_available;
    assign cfg_ready = |eligible;
    assign handshake = cfg_valid && cfg_ready;
    assign accept    = out_valid && out_ready;
    // isolate the lowest set bit of eligible
    assign dispatch  = handshake ? (eligible & (~eligible + 1'b1)) : '0;

    always_comb begin
        for (int k = 0; k < N_REDUCER; k++)
            rr_idx[k] = IDX_W'((32'(rr_ptr) + 32'(k)) % N_REDUCER);
    end

    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 0; k < N_REDUCER; k++) begin
            if (!pick_found && pending[rr_idx[k]]) begin
                pick_found = 1'b1;
                pick       = rr_idx[k];
            end
        end
    end

    assign load_en = pick_found && (!out_valid || out_ready);

    always_comb begin
        load_vec   = '0;
        accept_vec = '0;
        load_vec[pick]          = load_en;
        accept_vec[out_reducer] = accept;
    end

    always_comb begin
        busy_sum = '0;
        for (int i = 0; i < N_REDUCER; i++)
            busy_sum = busy_sum + CNT_W'(busy_next[i]);
    end

    for (genvar g = 0; g < N_REDUCER; g++) begin : g_slot
        patch_reducer_slot #(
            .FP_SIZE (FP_SIZE),
            .ID_SIZE (ID_SIZE)
        ) u_slot (
            .dram_clk  (dram_clk),
            .reset     (reset),
            .dispatch  (dispatch[g]),
            .id_in     (cfg_id),
            .sum_rdy   (red_sum_rdy[g]),
            .sum_in    (red_sum[g*FP_SIZE +: FP_SIZE]),
            .load      (load_vec[g]),
            .accept    (accept_vec[g]),
            .idle      (idle[g]),
            .pending   (pending[g]),
            .busy_next (busy_next[g]),
            .proto_hit (proto_hit[g]),
            .sum       (slot_sum[g]),
            .id        (slot_id[g])
        );
    end

    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset) begin
            red_init    <= '0;
            red_col     <= '0;
            red_row     <= '0;
            red_weights <= '0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_id      <= '0;
            out_reducer <= '0;
            rr_ptr      <= '0;
            busy_count  <= '0;
            proto_err   <= 1'b0;
        end else begin
            red_init   <= dispatch;
            busy_count <= busy_sum;
            if (handshake) begin
                red_col     <= cfg_col;
                red_row     <= cfg_row;
                red_weights <= cfg_weights;
            end
            if (|proto_hit) proto_err <= 1'b1;
            // reload in the same edge as acceptance keeps the output stream gapless
            if (load_en) begin
                out_valid   <= 1'b1;
                out_sum     <= slot_sum[pick];
                out_id      <= slot_id[pick];
                out_reducer <= pick;
                rr_ptr      <= IDX_W'((32'(pick) + 32'd1) % N_REDUCER);
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_patch_reducer_scheduler.sv
// Randomized and directed bench for patch_reducer_scheduler against a
// slot-level reference model.

module tb_patch_reducer_scheduler;
    localparam int N = 4, CW = 11, RW = 11, FP = 32, PS = 6, IW = 16;

    logic             dram_clk = 1'b0;
    logic             reset;
    logic             cfg_valid, cfg_ready;
    logic [CW-1:0]    cfg_col;
    logic [RW-1:0]    cfg_row;
    logic [PS*FP-1:0] cfg_weights;
    logic [IW-1:0]    cfg_id;
    logic [N-1:0]     red_available, red_init, red_sum_rdy;
    logic [CW-1:0]    red_col;
    logic [RW-1:0]    red_row;
    logic [PS*FP-1:0] red_weights;
    logic [N*FP-1:0]  red_sum;
    logic             out_valid, out_ready, proto_err;
    logic [FP-1:0]    out_sum;
    logic [IW-1:0]    out_id;
    logic [1:0]       out_reducer;
    logic [2:0]       busy_count;

    patch_reducer_scheduler dut (
        .dram_clk(dram_clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_col(cfg_col), .cfg_row(cfg_row),
        .cfg_weights(cfg_weights), .cfg_id(cfg_id), .red_available(red_available),
        .red_init(red_init), .red_col(red_col), .red_row(red_row), .red_weights(red_weights),
        .red_sum_rdy(red_sum_rdy), .red_sum(red_sum), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_id(out_id), .out_reducer(out_reducer),
        .busy_count(busy_count), .proto_err(proto_err)
    );

    always #5 dram_clk = ~dram_clk;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: slot phase 0 free, 1 waiting on reducer, 2 sum held
    int               ms [N];
    logic [IW-1:0]    mid [N];
    logic [FP-1:0]    msum [N];
    bit               mld [N];
    bit               o_v, m_perr;
    logic [FP-1:0]    o_sum;
    logic [IW-1:0]    o_id;
    int               o_red, ptr;
    logic [N-1:0]     m_init;
    logic [CW-1:0]    m_col;
    logic [RW-1:0]    m_row;
    logic [PS*FP-1:0] m_w;

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            ms[i] = 0; mid[i] = '0; msum[i] = '0; mld[i] = 0;
        end
        o_v = 0; m_perr = 0; o_sum = '0; o_id = '0; o_red = 0; ptr = 0;
        m_init = '0; m_col = '0; m_row = '0; m_w = '0;
    endtask

    task automatic m_edge();
        int d, pk;
        bit acc;
        int old [N];
        d = -1; pk = -1;
        old = ms;
        for (int i = N - 1; i >= 0; i--)
            if (ms[i] == 0 && red_available[i]) d = i;
        acc = o_v && out_ready;
        if (!o_v || out_ready)
            for (int k = 0; k < N; k++)
                if (pk < 0 && ms[(ptr + k) % N] == 2 && !mld[(ptr + k) % N]) pk = (ptr + k) % N;
        for (int i = 0; i < N; i++)
            if (red_sum_rdy[i]) begin
                if (old[i] == 1) begin ms[i] = 2; msum[i] = red_sum[i*FP +: FP]; end
                else m_perr = 1;
            end
        if (acc) begin ms[o_red] = 0; mld[o_red] = 0; end
        m_init = '0;
        if (cfg_valid && d >= 0) begin
            ms[d] = 1; mid[d] = cfg_id; m_init[d] = 1'b1;
            m_col = cfg_col; m_row = cfg_row; m_w = cfg_weights;
        end
        if (pk >= 0) begin
            mld[pk] = 1; o_v = 1; o_sum = msum[pk]; o_id = mid[pk]; o_red = pk; ptr = (pk + 1) % N;
        end else if (acc) o_v = 0;
    endtask

    task automatic m_check(input string t);
        bit rdy;
        int b;
        rdy = 0; b = 0;
        for (int i = 0; i < N; i++) begin
            if (ms[i] == 0 && red_available[i]) rdy = 1;
            if (ms[i] != 0) b++;
        end
        chk({t, ".out_valid"},   out_valid,   o_v);
        chk({t, ".out_sum"},     out_sum,     o_sum);
        chk({t, ".out_id"},      out_id,      o_id);
        chk({t, ".out_reducer"}, out_reducer, o_red);
        chk({t, ".red_init"},    red_init,    m_init);
        chk({t, ".red_col"},     red_col,     m_col);
        chk({t, ".red_row"},     red_row,     m_row);
        chk({t, ".red_weights"}, red_weights, m_w);
        chk({t, ".busy_count"},  busy_count,  b);
        chk({t, ".proto_err"},   proto_err,   m_perr);
        chk({t, ".cfg_ready"},   cfg_ready,   rdy);
    endtask

    task automatic cyc(input string t = "cyc");
        @(posedge dram_clk);
        m_edge();
        @(negedge dram_clk);
        m_check(t);
    endtask

    task automatic clear_in();
        cfg_valid = 0; cfg_col = '0; cfg_row = '0; cfg_weights = '0; cfg_id = '0;
        red_sum_rdy = '0; red_sum = '0; out_ready = 0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1;
        #1;
        m_reset();
        m_check("rst");
        @(negedge dram_clk);
        reset = 0;
    endtask

    function automatic logic [PS*FP-1:0] rnd_w();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset = 0;
        red_available = '1;
        clear_in();
        #2;
        do_reset();

        // four configs back-to-back fill every slot in index order
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1; cfg_id = IW'(i + 1);
            cfg_col = CW'($urandom); cfg_row = RW'($urandom); cfg_weights = rnd_w();
            cyc("fill");
            chk("fill.red_init", red_init, 256'(1) << i);
        end
        cfg_valid = 0;
        chk("fill.cfg_ready", cfg_ready, 0);
        chk("fill.busy", busy_count, 4);

        // finish slot 0 so the round-robin pointer sits at 1, then refill it
        red_sum_rdy = 4'b0001; red_sum = {96'h0, 32'h3f800000};
        cyc();
        red_sum_rdy = '0;
        cyc();
        chk("rr0.out_reducer", out_reducer, 0);
        out_ready = 1;
        cyc();
        out_ready = 0; cfg_valid = 1; cfg_id = 16'd5;
        cyc();
        chk("rr0.redispatch", red_init, 4'b0001);
        cfg_valid = 0;
        red_sum_rdy = 4'b0101; red_sum = {32'h0, 32'h40400000, 32'h0, 32'h40a00000};
        out_ready = 1;
        cyc();
        red_sum_rdy = '0;
        cyc();
        chk("rr.first_idx", out_reducer, 2);
        chk("rr.first_sum", out_sum, 32'h40400000);
        chk("rr.first_id", out_id, 3);
        cyc();
        chk("rr.second_idx", out_reducer, 0);
        chk("rr.second_sum", out_sum, 32'h40a00000);
        chk("rr.second_id", out_id, 5);
        cyc();
        chk("rr.drained", out_valid, 0);
        out_ready = 0;

        // hold a result for ten cycles while its reducer is the only available one
        red_sum_rdy = 4'b0010; red_sum = {64'h0, 32'h40e00000, 32'h0};
        cyc();
        red_sum_rdy = '0;
        cyc();
        red_available = 4'b0010; cfg_valid = 1; cfg_id = 16'd9;
        for (int i = 0; i < 10; i++) begin
            cyc("hold");
            chk("hold.sum", out_sum, 32'h40e00000);
            chk("hold.idx", out_reducer, 1);
            chk("hold.rdy", cfg_ready, 0);
        end
        out_ready = 1;
        cyc();
        chk("hold.no_same_cycle", red_init, 0);
        out_ready = 0;
        cyc();
        chk("hold.redispatch", red_init, 4'b0010);
        cfg_valid = 0;

        // partial availability picks the lowest available reducer
        do_reset();
        red_available = 4'b1010; cfg_valid = 1; cfg_col = 11'd100; cfg_row = 11'd7;
        cfg_weights = rnd_w();
        cyc();
        chk("avail.init", red_init, 4'b0010);
        chk("avail.col", red_col, 100);
        chk("avail.row", red_row, 7);
        cfg_valid = 0;

        // stray sum strobe on an idle slot
        red_sum_rdy = 4'b1000; red_sum = {$urandom, 96'h0};
        cyc();
        red_sum_rdy = '0;
        cyc(); cyc();
        chk("stray.proto_err", proto_err, 1);
        chk("stray.out_valid", out_valid, 0);

        // reset with work in flight and a result held
        do_reset();
        red_available = '1;
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1; cfg_id = IW'(20 + i); cfg_weights = rnd_w();
            cyc();
        end
        cfg_valid = 0;
        red_sum_rdy = 4'b1000; red_sum = {32'h41000000, 96'h0};
        cyc();
        red_sum_rdy = '0;
        cyc();
        chk("flight.out_valid", out_valid, 1);
        do_reset();
        chk("flight.rst_valid", out_valid, 0);
        chk("flight.rst_busy", busy_count, 0);
        red_sum_rdy = 4'b0001;
        cyc();
        red_sum_rdy = '0;
        cyc();
        chk("flight.no_output", out_valid, 0);
        chk("flight.proto_err", proto_err, 1);

        // randomized traffic with periodic resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 399) do_reset();
            cfg_valid = 1'($urandom % 2);
            cfg_id = IW'($urandom); cfg_col = CW'($urandom); cfg_row = RW'($urandom);
            cfg_weights = rnd_w();
            red_available = N'($urandom | $urandom);
            red_sum = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < N; i++)
                red_sum_rdy[i] = (ms[i] == 1) ? ($urandom % 4 == 0) : ($urandom % 128 == 0);
            out_ready = ($urandom % 3 != 0);
            cyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/patch_reducer_scheduler.md
PATCH_REDUCER_SCHEDULER -- requirements
Module: patch_reducer_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_REDUCER, 4, number of attached patch row reducers
  N_COL_SIZE, 11, column field width
  N_ROW_SIZE, 11, row field width
  FP_SIZE, 32, float word width
  PATCH_SIZE, 6, weights per patch row
  ID_SIZE, 16, patch tag width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  dram_clk  in  1  clock, all logic on posedge
  reset  in  1  asynchronous, active-high
  cfg_valid  in  1  patch config offered
  cfg_ready  out  1  config accepted when cfg_valid&&cfg_ready
  cfg_col  in  N_COL_SIZE  patch start column
  cfg_row  in  N_ROW_SIZE  patch row
  cfg_weights  in  PATCH_SIZE*FP_SIZE  patch weights, weight i at [i*FP_SIZE+:FP_SIZE]
  cfg_id  in  ID_SIZE  patch tag returned with the sum
  red_available  in  N_REDUCER  per-reducer idle flag
  red_init  out  N_REDUCER  one-hot, single-cycle config strobe
  red_col  out  N_COL_SIZE  broadcast column
  red_row  out  N_ROW_SIZE  broadcast row
  red_weights  out  PATCH_SIZE*FP_SIZE  broadcast weights
  red_sum_rdy  in  N_REDUCER  per-reducer single-cycle sum strobe
  red_sum  in  N_REDUCER*FP_SIZE  per-reducer sum, reducer i at [i*FP_SIZE+:FP_SIZE]
  out_valid  out  1  result held
  out_ready  in  1  result consumed when out_valid&&out_ready
  out_sum  out  FP_SIZE  patch row sum
  out_id  out  ID_SIZE  tag of the patch
  out_reducer  out  log2(N_REDUCER)  index of the producing reducer
  busy_count  out  log2(N_REDUCER)+1  slots not in IDLE
  proto_err  out  1  sticky protocol error

Function
REQ-003 Each reducer index SHALL have a slot FSM: IDLE -> DISPATCHED on config handshake; DISPATCHED -> DONE on red_sum_rdy[i]; DONE -> IDLE on output acceptance of index i.
REQ-004 A slot SHALL be eligible when it is IDLE and red_available[i]=1; cfg_ready SHALL be combinational OR of eligibility.
REQ-005 On handshake the lowest-index eligible slot SHALL be chosen; its slot SHALL enter DISPATCHED and cfg_id SHALL be stored in that slot.
REQ-006 The cycle after handshake, red_init SHALL be one-hot on the chosen index for exactly one cycle, with red_col/red_row/red_weights registered copies of the accepted config; red_init SHALL be 0 otherwise.
REQ-007 Back-to-back handshakes SHALL be allowed every cycle; a slot dispatched in cycle t SHALL NOT be eligible in cycle t+1.
REQ-008 red_sum_rdy[i] in DISPATCHED SHALL capture red_sum[i] into slot i in the same edge; slot enters DONE.
REQ-009 red_sum_rdy[i] while slot i is IDLE or DONE SHALL be ignored (no capture) and SHALL set proto_err.
REQ-010 Output stage SHALL be one register (EMPTY/FULL); it SHALL load when EMPTY or being accepted this cycle, from a DONE slot not already loaded.
REQ-011 Output selection SHALL be round-robin: search begins at the index after the last loaded one, modulo N_REDUCER.
REQ-012 out_sum/out_id/out_reducer SHALL stay stable while out_valid=1 and out_ready=0.
REQ-013 Acceptance SHALL return the loaded slot to IDLE at that edge; it SHALL be eligible for dispatch the next cycle, not the same cycle.
REQ-014 Minimum latency: red_sum_rdy at edge t -> DONE after t -> out_valid after t+1.
REQ-015 busy_count SHALL equal the number of non-IDLE slots, registered.
REQ-016 Dispatch, capture and acceptance on different indices in the same cycle SHALL all take effect.

Reset
REQ-017 reset SHALL force all slots IDLE, output stage EMPTY, round-robin pointer to 0, and red_init, out_valid, out_sum, out_id, out_reducer, red_col, red_row, red_weights, busy_count and proto_err to 0; cfg_ready follows REQ-004.
REQ-018 Reset mid-operation SHALL discard all in-flight patches and held results without emitting them.

Verification
REQ-019 N_REDUCER=4, all available, 4 configs id 1..4 back-to-back -> red_init 0001,0010,0100,1000 on consecutive cycles; cfg_ready=0 on the 5th; busy_count=4.
REQ-020 red_available=1010, one config col=100 row=7 -> red_init=0010 next cycle, red_col=100, red_row=7.
REQ-021 Reducers 2 and 0 pulse sum_rdy in the same cycle with sums 3.0 and 5.0, out_ready=1, pointer 1 -> out_reducer 2 (sum 3.0) then 0 (sum 5.0) on consecutive cycles.
REQ-022 out_ready=0 for 10 cycles with result held -> outputs stable; slot stays non-eligible; after accept, dispatch to that index on the following cycle.
REQ-023 red_sum_rdy[3] while slot 3 IDLE -> no output, proto_err=1 until reset.
REQ-024 reset asserted with 3 slots DISPATCHED and out_valid=1 -> all outputs 0 immediately; later red_sum_rdy causes no output and sets proto_err.
